// File: rtl/wmi_slave_responder_if.sv
// wmi_slave_responder_if: WMI slave-side request, write-data and response bundle.
interface wmi_slave_responder_if;
    logic [2:0]  wmiS_MCmd;
    logic        wmiS_MReqLast;
    logic        wmiS_MReqInfo;
    logic        wmiS_MAddrSpace;
    logic [13:0] wmiS_MAddr;
    logic [11:0] wmiS_MBurstLength;
    logic        wmiS_MDataValid;
    logic        wmiS_MDataLast;
    logic [31:0] wmiS_MData;
    logic [3:0]  wmiS_MDataByteEn;
    logic [31:0] wmiS_MFlag;
    logic        wmiS_MReset_n;
    logic [1:0]  wmiS_SResp;
    logic [31:0] wmiS_SData;
    logic        wmiS_SRespLast;
    logic        wmiS_SThreadBusy;
    logic        wmiS_SDataThreadBusy;
    logic [31:0] wmiS_SFlag;
    logic        wmiS_SReset_n;
    modport master (
        output wmiS_MCmd, wmiS_MReqLast, wmiS_MReqInfo, wmiS_MAddrSpace, wmiS_MAddr, wmiS_MBurstLength,
               wmiS_MDataValid, wmiS_MDataLast, wmiS_MData, wmiS_MDataByteEn, wmiS_MFlag, wmiS_MReset_n,
        input  wmiS_SResp, wmiS_SData, wmiS_SRespLast, wmiS_SThreadBusy, wmiS_SDataThreadBusy,
               wmiS_SFlag, wmiS_SReset_n
    );
    modport slave (
        input  wmiS_MCmd, wmiS_MReqLast, wmiS_MReqInfo, wmiS_MAddrSpace, wmiS_MAddr, wmiS_MBurstLength,
               wmiS_MDataValid, wmiS_MDataLast, wmiS_MData, wmiS_MDataByteEn, wmiS_MFlag, wmiS_MReset_n,
        output wmiS_SResp, wmiS_SData, wmiS_SRespLast, wmiS_SThreadBusy, wmiS_SDataThreadBusy,
               wmiS_SFlag, wmiS_SReset_n
    );
endinterface

// File: rtl/wmi_slave_responder.sv
// wmi_slave_responder: WMI burst slave backed by a 2^ADDR_W x 32-bit memory.
module wmi_slave_responder #(
    parameter int ADDR_W = 8
) (
    input logic clk,
    input logic reset,
    wmi_slave_responder_if.slave wmi
);
    typedef enum logic [1:0] {IDLE, WDATA, RDATA} state_t;
    state_t state;
    logic [ADDR_W-1:0] addr;
    logic [11:0] cnt;
    logic [15:0] burstCnt;
    logic [7:0] errCnt;
    logic [1:0] sResp;
    logic [31:0] sData;
    logic sRespLast;
    logic sReset_n;
    logic [31:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] reqAddr;
    logic [11:0] reqCnt;
    logic wrBeat, wrEnd, mismatch, errSat;
    always_comb begin
        reqAddr = wmi.wmiS_MAddr[ADDR_W+1:2];
        reqCnt = (wmi.wmiS_MBurstLength == 12'd0) ? 12'd0 : wmi.wmiS_MBurstLength - 12'd1;
        wrBeat = (state == WDATA) && wmi.wmiS_MDataValid && wmi.wmiS_MReset_n;
        wrEnd = wrBeat && ((cnt == 12'd0) || wmi.wmiS_MDataLast);
        mismatch = wrBeat && (wmi.wmiS_MDataLast != (cnt == 12'd0));
        errSat = (errCnt == 8'hFF);
    end
    // Memory is deliberately left out of reset; writes are only suppressed on the reset cycle.
    always_ff @(posedge clk)
        if (!reset && wrBeat)
            for (int i = 0; i < 4; i++)
                if (wmi.wmiS_MDataByteEn[i]) mem[addr][8*i +: 8] <= wmi.wmiS_MData[8*i +: 8];
    always_ff @(posedge clk) sReset_n <= ~reset;
    // cnt holds the beats still to go after the current one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sResp <= 2'b00;
            sData <= 32'd0;
            sRespLast <= 1'b0;
            burstCnt <= 16'd0;
            errCnt <= 8'd0;
            addr <= '0;
            cnt <= 12'd0;
        end else if (!wmi.wmiS_MReset_n) begin
            state <= IDLE;
            sResp <= 2'b00;
            sData <= 32'd0;
            sRespLast <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wmi.wmiS_MCmd == 3'b001) begin
                        state <= WDATA;
                        addr <= reqAddr;
                        cnt <= reqCnt;
                    end else if (wmi.wmiS_MCmd == 3'b010) begin
                        state <= RDATA;
                        sResp <= 2'b01;
                        sData <= mem[reqAddr];
                        sRespLast <= (reqCnt == 12'd0);
                        addr <= reqAddr + 1'b1;
                        cnt <= reqCnt;
                    end else if (wmi.wmiS_MCmd != 3'b000 && !errSat) begin
                        errCnt <= errCnt + 8'd1;
                    end
                end
                WDATA: begin
                    if (wrBeat) begin
                        addr <= addr + 1'b1;
                        cnt <= cnt - 12'd1;
                    end
                    if (wrEnd) begin
                        state <= IDLE;
                        burstCnt <= burstCnt + 16'd1;
                    end
                    if (mismatch && !errSat) errCnt <= errCnt + 8'd1;
                end
                RDATA: begin
                    if (cnt != 12'd0) begin
                        sData <= mem[addr];
                        sRespLast <= (cnt == 12'd1);
                        addr <= addr + 1'b1;
                        cnt <= cnt - 12'd1;
                    end else begin
                        state <= IDLE;
                        sResp <= 2'b00;
                        sData <= 32'd0;
                        sRespLast <= 1'b0;
                        burstCnt <= burstCnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign wmi.wmiS_SResp = sResp;
    assign wmi.wmiS_SData = sData;
    assign wmi.wmiS_SRespLast = sRespLast;
    assign wmi.wmiS_SThreadBusy = !sReset_n || (state != IDLE);
    assign wmi.wmiS_SDataThreadBusy = (state != WDATA);
    assign wmi.wmiS_SFlag = {errCnt, 8'h00, burstCnt};
    assign wmi.wmiS_SReset_n = sReset_n;
endmodule

// File: tb/tb_wmi_slave_responder.sv
// tb_wmi_slave_responder: scoreboard bench for wmi_slave_responder.
module tb_wmi_slave_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    wmi_slave_responder_if wmi();
    wmi_slave_responder #(.ADDR_W(8)) dut (.clk(clk), .reset(reset), .wmi(wmi));
    typedef struct {logic [31:0] data; logic last; int at;} beat_t;
    beat_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int burstExp = 0;
    int errExp = 0;
    logic [31:0] model [256];
    logic [31:0] wd [16];
    logic [3:0] wbe [16];
    always @(posedge clk) cyc <= cyc + 1;
    // Every DVA beat must match the head of the queue in data, last flag and cycle.
    always @(negedge clk) begin
        beat_t e;
        if (cyc > 0) begin
            if (wmi.wmiS_SResp === 2'b01) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_dva: got data=%h last=%b at cycle %0d, expected no beat", wmi.wmiS_SData, wmi.wmiS_SRespLast, cyc);
                end else begin
                    e = q.pop_front();
                    if (wmi.wmiS_SData !== e.data || wmi.wmiS_SRespLast !== e.last || cyc != e.at) begin
                        errors++;
                        $display("FAIL read_beat: got data=%h last=%b cycle=%0d, expected data=%h last=%b cycle=%0d", wmi.wmiS_SData, wmi.wmiS_SRespLast, cyc, e.data, e.last, e.at);
                    end
                end
            end else if (wmi.wmiS_SResp !== 2'b00 || wmi.wmiS_SRespLast !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL idle_resp: got resp=%b last=%b, expected 00/0", wmi.wmiS_SResp, wmi.wmiS_SRespLast);
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
    task tick;
        @(posedge clk);
        #1;
    endtask
    task automatic wait_idle;
        int n = 0;
        while (wmi.wmiS_SThreadBusy !== 1'b0 && n < 50) begin
            tick;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got SThreadBusy=%b for 50 cycles, expected 0", wmi.wmiS_SThreadBusy);
        end
    endtask
    task automatic drain;
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            tick;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d beats outstanding, expected 0", q.size());
            q.delete();
        end
        tick;
    endtask
    task automatic check_flag(input string name);
        logic [31:0] exp;
        logic [31:0] e32;
        logic [31:0] b32;
        e32 = errExp;
        b32 = burstExp;
        exp = {e32[7:0], 8'h00, b32[15:0]};
        checks++;
        if (wmi.wmiS_SFlag !== exp) begin
            errors++;
            $display("FAIL %s: got SFlag=%h, expected %h", name, wmi.wmiS_SFlag, exp);
        end
    endtask
    task automatic rd(input logic [13:0] a, input int len);
        int n;
        int w;
        n = (len == 0) ? 1 : len;
        w = int'(a[9:2]);
        wait_idle;
        wmi.wmiS_MCmd = 3'b010;
        wmi.wmiS_MAddr = a;
        wmi.wmiS_MBurstLength = 12'(len);
        tick;
        wmi.wmiS_MCmd = 3'b000;
        for (int k = 0; k < n; k++) q.push_back('{model[(w + k) % 256], k == n - 1, cyc + k});
        burstExp++;
        drain;
    endtask
    task automatic wr(input logic [13:0] a, input int len, input int lastBeat);
        int n;
        int w;
        n = (len == 0) ? 1 : len;
        w = int'(a[9:2]);
        wait_idle;
        wmi.wmiS_MCmd = 3'b001;
        wmi.wmiS_MAddr = a;
        wmi.wmiS_MBurstLength = 12'(len);
        tick;
        wmi.wmiS_MCmd = 3'b000;
        for (int k = 0; k < n; k++) begin
            wmi.wmiS_MDataValid = 1'b1;
            wmi.wmiS_MData = wd[k];
            wmi.wmiS_MDataByteEn = wbe[k];
            wmi.wmiS_MDataLast = (k == lastBeat);
            checks++;
            if (wmi.wmiS_SDataThreadBusy !== 1'b0) begin
                errors++;
                $display("FAIL wdata_busy: got SDataThreadBusy=%b on beat %0d, expected 0", wmi.wmiS_SDataThreadBusy, k);
            end
            for (int i = 0; i < 4; i++)
                if (wbe[k][i]) model[(w + k) % 256][8*i +: 8] = wd[k][8*i +: 8];
            tick;
            if (k == lastBeat) break;
        end
        wmi.wmiS_MDataValid = 1'b0;
        wmi.wmiS_MDataLast = 1'b0;
        burstExp++;
        if (lastBeat != n - 1) errExp++;
        tick;
    endtask
    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        checks += 7;
        if (wmi.wmiS_SResp !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b, expected 00", wmi.wmiS_SResp); end
        if (wmi.wmiS_SData !== 32'd0) begin errors++; $display("FAIL reset_data: got %h, expected 0", wmi.wmiS_SData); end
        if (wmi.wmiS_SRespLast !== 1'b0) begin errors++; $display("FAIL reset_last: got %b, expected 0", wmi.wmiS_SRespLast); end
        if (wmi.wmiS_SThreadBusy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b, expected 1", wmi.wmiS_SThreadBusy); end
        if (wmi.wmiS_SDataThreadBusy !== 1'b1) begin errors++; $display("FAIL reset_dbusy: got %b, expected 1", wmi.wmiS_SDataThreadBusy); end
        if (wmi.wmiS_SFlag !== 32'd0) begin errors++; $display("FAIL reset_flag: got %h, expected 0", wmi.wmiS_SFlag); end
        if (wmi.wmiS_SReset_n !== 1'b0) begin errors++; $display("FAIL reset_sreset_n: got %b, expected 0", wmi.wmiS_SReset_n); end
        reset = 1'b0;
        tick;
        checks += 2;
        if (wmi.wmiS_SReset_n !== 1'b1) begin errors++; $display("FAIL sreset_release: got %b, expected 1", wmi.wmiS_SReset_n); end
        if (wmi.wmiS_SThreadBusy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, expected 0", wmi.wmiS_SThreadBusy); end
    endtask
    task automatic test_basic;
        for (int k = 0; k < 4; k++) begin
            wd[k] = 32'h11111111 * (k + 1);
            wbe[k] = 4'hF;
        end
        wr(14'h040, 4, 3);
        rd(14'h040, 4);
        checks++;
        if (wmi.wmiS_SFlag !== 32'h00000002) begin
            errors++;
            $display("FAIL basic_flag: got %h, expected 00000002", wmi.wmiS_SFlag);
        end
    endtask
    task automatic test_byteen;
        wd[0] = 32'hFFFFFFFF;
        wbe[0] = 4'hF;
        wr(14'h080, 1, 0);
        wd[0] = 32'hAABBCCDD;
        wbe[0] = 4'b0101;
        wr(14'h080, 1, 0);
        checks++;
        if (model[32] !== 32'hFFBBFFDD) begin
            errors++;
            $display("FAIL byteen_model: got %h, expected FFBBFFDD", model[32]);
        end
        rd(14'h080, 1);
        check_flag("byteen_flag");
    endtask
    task automatic test_wrap;
        for (int k = 0; k < 3; k++) begin
            wd[k] = 32'hC0DE0000 + k;
            wbe[k] = 4'hF;
        end
        wr(14'h3FC, 3, 2);
        rd(14'h3FC, 3);
        check_flag("wrap_flag");
    endtask
    task automatic test_early_last;
        for (int k = 0; k < 4; k++) begin
            wd[k] = 32'hA0 + k;
            wbe[k] = 4'hF;
        end
        wr(14'h100, 4, 3);
        for (int k = 0; k < 4; k++) wd[k] = 32'hB0 + k;
        wr(14'h100, 4, 1);
        check_flag("early_last_flag");
        rd(14'h100, 4);
        wait_idle;
        wmi.wmiS_MCmd = 3'b011;
        tick;
        wmi.wmiS_MCmd = 3'b000;
        errExp++;
        tick;
        check_flag("illegal_cmd_flag");
        checks++;
        if (wmi.wmiS_SThreadBusy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_cmd_state: got SThreadBusy=%b, expected 0", wmi.wmiS_SThreadBusy);
        end
    endtask
    task automatic test_abort;
        wait_idle;
        wmi.wmiS_MCmd = 3'b010;
        wmi.wmiS_MAddr = 14'h040;
        wmi.wmiS_MBurstLength = 12'd8;
        tick;
        wmi.wmiS_MCmd = 3'b000;
        for (int k = 0; k < 3; k++) q.push_back('{model[16 + k], 1'b0, cyc + k});
        tick;
        tick;
        wmi.wmiS_MReset_n = 1'b0;
        tick;
        wmi.wmiS_MReset_n = 1'b1;
        drain;
        check_flag("abort_flag");
        checks++;
        if (wmi.wmiS_SThreadBusy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got SThreadBusy=%b, expected 0", wmi.wmiS_SThreadBusy);
        end
        rd(14'h040, 2);
    endtask
    task automatic test_len0;
        rd(14'h044, 0);
        check_flag("len0_flag");
    endtask
    task automatic test_back_to_back;
        wd[0] = 32'h12345678;
        wd[1] = 32'h9ABCDEF0;
        wbe[0] = 4'hF;
        wbe[1] = 4'hF;
        wr(14'h200, 2, 5);
        rd(14'h200, 2);
        rd(14'h1FC, 3);
        check_flag("b2b_flag");
    endtask
    initial begin
        wmi.wmiS_MCmd = 3'b000;
        wmi.wmiS_MReqLast = 1'b0;
        wmi.wmiS_MReqInfo = 1'b0;
        wmi.wmiS_MAddrSpace = 1'b0;
        wmi.wmiS_MAddr = 14'd0;
        wmi.wmiS_MBurstLength = 12'd0;
        wmi.wmiS_MDataValid = 1'b0;
        wmi.wmiS_MDataLast = 1'b0;
        wmi.wmiS_MData = 32'd0;
        wmi.wmiS_MDataByteEn = 4'h0;
        wmi.wmiS_MFlag = 32'd0;
        wmi.wmiS_MReset_n = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = 32'd0;
        test_reset;
        test_basic;
        test_byteen;
        test_wrap;
        test_early_last;
        test_abort;
        test_len0;
        test_back_to_back;
        drain;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wmi_slave_responder.md
WMI_SLAVE_RESPONDER -- requirements
Module: wmi_slave_responder

Interface
REQ-001 Parameter ADDR_W, default 8, word-address bits of internal memory (2^ADDR_W x 32-bit words).
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 wmiS_MCmd  in  3  request command: 3'b001 WR, 3'b010 RD, 3'b000 idle, others illegal.
REQ-005 wmiS_MReqLast, wmiS_MReqInfo, wmiS_MAddrSpace  in  1 each  accepted, ignored.
REQ-006 wmiS_MAddr  in  14  byte address; word index = MAddr[ADDR_W+1:2].
REQ-007 wmiS_MBurstLength  in  12  burst length N in words; 0 treated as 1.
REQ-008 wmiS_MDataValid / wmiS_MDataLast  in  1 each  write-data beat valid / last beat marker.
REQ-009 wmiS_MData  in  32 / wmiS_MDataByteEn  in  4  write data / per-byte enables.
REQ-010 wmiS_MFlag  in  32  ignored; wmiS_MReset_n  in  1  master reset, active-low.
REQ-011 wmiS_SResp  out  2  2'b01 DVA on read data, else 2'b00; wmiS_SData  out  32  read data.
REQ-012 wmiS_SRespLast  out  1  marks final read beat.
REQ-013 wmiS_SThreadBusy / wmiS_SDataThreadBusy  out  1 each  request / write-data backpressure.
REQ-014 wmiS_SFlag  out  32  status {err_cnt[7:0], 8'h00, burst_cnt[15:0]}; wmiS_SReset_n  out  1  slave reset, active-low.

Function
REQ-015 States IDLE, WDATA, RDATA; outputs depend only on registers (no input-to-output combinational path).
REQ-016 SThreadBusy SHALL be 1 whenever state != IDLE, 0 in IDLE; SDataThreadBusy SHALL be 0 only in WDATA.
REQ-017 Request accepted at cycle T only in IDLE with MCmd WR/RD; captures word address A and N.
REQ-018 Illegal MCmd in IDLE: no state change, err_cnt += 1.
REQ-019 WR accepted at T -> WDATA from T+1; each cycle in WDATA with MDataValid=1 writes bytes i where ByteEn[i]=1 to mem[(A+k) mod 2^ADDR_W], k = beat index from 0.
REQ-020 WDATA ends after beat N or beat carrying MDataLast, whichever first; next state IDLE; burst_cnt += 1.
REQ-021 Write mismatch (MDataLast on beat k<N-1, or beat N-1 without MDataLast): err_cnt += 1; burst still ends per REQ-020.
REQ-022 RD accepted at T -> SResp=DVA, SData=mem[(A+k) mod 2^ADDR_W] at cycle T+1+k for k=0..N-1; SRespLast=1 only at T+N; SResp=0, SRespLast=0 otherwise.
REQ-023 Read state returns IDLE at T+N+1; burst_cnt += 1 at end; earliest next accept T+N+1.
REQ-024 Address wraps modulo 2^ADDR_W within a burst; MAddr bits above ADDR_W+1 ignored.
REQ-025 burst_cnt wraps at 16 bits; err_cnt saturates at 255.
REQ-026 Reads reflect all writes completed in prior cycles (read-after-write in next burst returns new data).

Reset
REQ-027 reset=1: state IDLE, SResp=0, SData=0, SRespLast=0, SThreadBusy=1, SDataThreadBusy=1, burst_cnt=0, err_cnt=0, SReset_n=0; memory not cleared.
REQ-028 SReset_n SHALL be a register = ~reset, going 1 the cycle after reset deasserts.
REQ-029 MReset_n=0 (sampled synchronously) aborts any burst to IDLE and clears SResp/SData/SRespLast; counters and memory retained; no burst_cnt/err_cnt update for aborted burst.
REQ-030 reset mid-burst: burst discarded, no further DVA beats or memory writes after the reset cycle.

Verification
REQ-031 WR A=0x010 (MAddr=0x040), N=4, data 0x11111111..0x44444444, ByteEn=4'hF, MDataLast on beat 4 -> then RD same addr N=4 returns same 4 words at T+1..T+4, SRespLast at T+4, SFlag=0x00000002.
REQ-032 WR N=1 MData=0xAABBCCDD ByteEn=4'b0101 over word 0xFFFFFFFF -> RD returns 0xFFBBFFDD.
REQ-033 RD MAddr=0x3FC (word 255, ADDR_W=8), N=3 -> words 255, 0, 1 returned in order.
REQ-034 WR N=4 with MDataLast on beat 2 -> WDATA exits after beat 2, only 2 words written, err_cnt=1, burst_cnt+1; MCmd=3'b011 in IDLE -> err_cnt=2, no response.
REQ-035 RD N=8 with MReset_n=0 at T+3 -> DVA beats stop from T+4, SRespLast never asserted, burst_cnt unchanged, new RD accepted once MReset_n=1 in IDLE.
REQ-036 MBurstLength=0 RD -> exactly one DVA beat with SRespLast=1.
